// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: full-speed USB receive front end.
// Recovers bit timing, NRZI-decodes, unstuffs, and frames SYNC/EOP for the CRC checkers.
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 4,
    parameter int SAMPLE_POINT = CLKS_PER_BIT / 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic dp_in,
    input  logic dm_in,
    output logic bit_out,
    output logic shift,
    output logic packet_start,
    output logic eop,
    output logic rx_err,
    output logic receiving
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE = CW'(SAMPLE_POINT);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERROR} state_t;

    state_t state;
    logic [1:0] dp_sync, dm_sync;
    logic dp_prev, last_dp, j_seen;
    logic [CW-1:0] phase;
    logic [2:0] zero_count, ones_count;
    logic [1:0] se0_count;
    logic dp, dm, edge_det, strobe, se0, k, dec;

    assign dp = dp_sync[1];
    assign dm = dm_sync[1];
    assign edge_det = dp != dp_prev;
    assign strobe = (phase == SAMPLE) && !edge_det;
    assign se0 = !dp && !dm;
    assign k = !dp && dm;
    // IDLE decodes against an implied J so the first K of SYNC reads as 0
    assign dec = dp == ((state == IDLE) ? 1'b1 : last_dp);
    assign receiving = (state == SYNC) || (state == DATA) || (state == EOP);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync <= 2'b11;
            dm_sync <= 2'b00;
            dp_prev <= 1'b1;
            last_dp <= 1'b1;
            phase <= '0;
            state <= IDLE;
            zero_count <= '0;
            ones_count <= '0;
            se0_count <= '0;
            j_seen <= 1'b0;
            bit_out <= 1'b0;
            shift <= 1'b0;
            packet_start <= 1'b0;
            eop <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            dp_sync <= {dp_sync[0], dp_in};
            dm_sync <= {dm_sync[0], dm_in};
            dp_prev <= dp;
            phase <= edge_det ? CW'(1) : (phase == LAST) ? '0 : phase + 1'b1;
            shift <= 1'b0;
            packet_start <= 1'b0;
            eop <= 1'b0;
            rx_err <= 1'b0;
            if (strobe) begin
                last_dp <= dp;
                case (state)
                    IDLE: if (k) begin
                        state <= SYNC;
                        zero_count <= 3'd1;
                    end
                    SYNC: if (se0) begin
                        rx_err <= 1'b1;
                        state <= ERROR;
                    end else if (!dec) begin
                        if (zero_count == 3'd7) state <= IDLE;
                        else zero_count <= zero_count + 3'd1;
                    end else if (zero_count == 3'd7) begin
                        packet_start <= 1'b1;
                        state <= DATA;
                        ones_count <= 3'd1;
                    end else state <= IDLE;
                    DATA: if (se0) begin
                        state <= EOP;
                        se0_count <= 2'd1;
                    end else if (ones_count == 3'd6) begin
                        if (dec) begin
                            rx_err <= 1'b1;
                            state <= ERROR;
                        end else ones_count <= '0;
                    end else begin
                        bit_out <= dec;
                        shift <= 1'b1;
                        ones_count <= dec ? ones_count + 3'd1 : '0;
                    end
                    EOP: if (se0) begin
                        if (se0_count == 2'd3) begin
                            rx_err <= 1'b1;
                            state <= ERROR;
                        end else se0_count <= se0_count + 2'd1;
                    end else if (dp) begin
                        eop <= 1'b1;
                        state <= IDLE;
                    end else begin
                        rx_err <= 1'b1;
                        state <= ERROR;
                    end
                    // j_seen self-clears on exit, so entry never needs to reset it
                    ERROR: begin
                        j_seen <= dp && !j_seen;
                        if (dp && j_seen) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: drives NRZI/stuffed line symbols built from payload bits
// and compares recovered bits and pulse counts with what the payload implies.
module tb_usb_rx_decoder;
    localparam int J = 0, K = 1, SE0 = 2;

    logic clk = 1'b0, n_rst = 1'b0, dp_in = 1'b1, dm_in = 1'b0;
    logic bit_out, shift, packet_start, eop, rx_err, receiving;
    int checks = 0, errors = 0;
    bit got[$];
    int tx[$];
    int n_ps = 0, n_eop = 0, n_err = 0, n_multi = 0, n_eop_rcv = 0, n_rcv = 0;
    int b_got, b_ps, b_eop, b_err, b_multi, b_eop_rcv, b_rcv;

    usb_rx_decoder #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .n_rst(n_rst), .dp_in(dp_in), .dm_in(dm_in),
        .bit_out(bit_out), .shift(shift), .packet_start(packet_start),
        .eop(eop), .rx_err(rx_err), .receiving(receiving)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (n_rst) begin
        if (shift) got.push_back(bit_out);
        n_ps += int'(packet_start);
        n_eop += int'(eop);
        n_err += int'(rx_err);
        n_rcv += int'(receiving);
        if (int'(shift) + int'(packet_start) + int'(eop) + int'(rx_err) > 1) n_multi++;
        if (eop && receiving) n_eop_rcv++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s);
        dp_in = (s == J);
        dm_in = (s == K);
    endtask

    task automatic mark();
        b_got = got.size();
        b_ps = n_ps; b_eop = n_eop; b_err = n_err;
        b_multi = n_multi; b_eop_rcv = n_eop_rcv; b_rcv = n_rcv;
    endtask

    // Jittered mode alternates 3 and 5 clk symbols around the nominal 4
    task automatic send(input bit jit);
        foreach (tx[i]) begin
            drive(tx[i]);
            repeat (jit ? ((i % 2 == 1) ? 5 : 3) : 4) @(negedge clk);
        end
        drive(J);
        repeat (24) @(negedge clk);
    endtask

    // SYNC + payload, NRZI encoded from J, with a 0 stuffed after six 1s
    task automatic build(input bit payload[$], input bit stuff);
        bit raw[$];
        int lvl, ones;
        lvl = J;
        ones = 0;
        tx.delete();
        for (int i = 0; i < 8; i++) raw.push_back(i == 7);
        foreach (payload[i]) raw.push_back(payload[i]);
        foreach (raw[i]) begin
            if (!raw[i]) lvl = (lvl == J) ? K : J;
            tx.push_back(lvl);
            ones = raw[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                lvl = (lvl == J) ? K : J;
                tx.push_back(lvl);
                ones = 0;
            end
        end
    endtask

    function automatic int pack(input bit q[$]);
        int v = 0;
        foreach (q[i]) if (i < 32) v[i] = q[i];
        return v;
    endfunction

    task automatic expect_pkt(input string tag, input bit exp_bits[$], input int ps, input int eo, input int er);
        bit obs[$];
        for (int i = b_got; i < got.size(); i++) obs.push_back(got[i]);
        chk({tag, " nbits"}, obs.size(), exp_bits.size());
        chk({tag, " bits"}, pack(obs), pack(exp_bits));
        chk({tag, " packet_start"}, n_ps - b_ps, ps);
        chk({tag, " eop"}, n_eop - b_eop, eo);
        chk({tag, " rx_err"}, n_err - b_err, er);
        chk({tag, " exclusive"}, n_multi - b_multi, 0);
        chk({tag, " eop_vs_receiving"}, n_eop_rcv - b_eop_rcv, 0);
        chk({tag, " receiving_at_end"}, int'(receiving), 0);
    endtask

    task automatic byte_bits(input logic [7:0] b, output bit q[$]);
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
    endtask

    initial begin
        bit pl[$];
        bit none[$];
        int len;
        bit jit;
        drive(J);
        repeat (3) @(negedge clk);
        chk("reset outputs", int'({bit_out, shift, packet_start, eop, rx_err, receiving}), 0);
        n_rst = 1'b1;
        mark();
        repeat (40) @(negedge clk);
        expect_pkt("idle", none, 0, 0, 0);

        byte_bits(8'hA5, pl);
        build(pl, 1'b1);
        tx.push_back(SE0); tx.push_back(SE0); tx.push_back(J);
        mark();
        send(1'b0);
        expect_pkt("a5", pl, 1, 1, 0);
        chk("a5 value", pack(pl), 32'hA5);
        chk("a5 receiving_seen", int'(n_rcv - b_rcv > 0), 1);

        pl = '{1, 1, 1, 1, 1, 1, 0};
        build(pl, 1'b1);
        chk("stuff symbols", tx.size(), 16);
        tx.push_back(SE0); tx.push_back(SE0); tx.push_back(J);
        mark();
        send(1'b0);
        expect_pkt("stuffed", pl, 1, 1, 0);

        pl = '{1, 1, 1, 1, 1, 1, 1};
        build(pl, 1'b0);
        mark();
        send(1'b0);
        pl = '{1, 1, 1, 1, 1};
        expect_pkt("stuff_err", pl, 1, 0, 1);
        byte_bits(8'h3C, pl);
        build(pl, 1'b1);
        tx.push_back(SE0); tx.push_back(SE0); tx.push_back(J);
        mark();
        send(1'b0);
        expect_pkt("after_err", pl, 1, 1, 0);

        tx = '{K, J, K, J, K, K, K, K, K};
        mark();
        send(1'b0);
        expect_pkt("bad_sync", none, 0, 0, 0);

        tx = '{K, J, K, SE0};
        mark();
        send(1'b0);
        expect_pkt("se0_sync", none, 0, 0, 1);

        byte_bits(8'hA5, pl);
        build(pl, 1'b1);
        tx.push_back(SE0); tx.push_back(SE0); tx.push_back(J);
        mark();
        send(1'b1);
        expect_pkt("a5_jitter", pl, 1, 1, 0);

        byte_bits(8'($urandom), pl);
        build(pl, 1'b1);
        tx.push_back(SE0); tx.push_back(K);
        mark();
        send(1'b0);
        expect_pkt("eop_k", pl, 1, 0, 1);

        byte_bits(8'($urandom), pl);
        build(pl, 1'b1);
        for (int i = 0; i < 4; i++) tx.push_back(SE0);
        tx.push_back(J);
        mark();
        send(1'b0);
        expect_pkt("eop_long", pl, 1, 0, 1);

        byte_bits(8'hA5, pl);
        build(pl, 1'b1);
        mark();
        for (int i = 0; i < 12; i++) begin
            drive(tx[i]);
            repeat (4) @(negedge clk);
        end
        #3 n_rst = 1'b0;
        drive(J);
        #1 chk("reset mid outputs", int'({bit_out, shift, packet_start, eop, rx_err, receiving}), 0);
        chk("reset mid partial", int'(got.size() - b_got > 0), 1);
        @(negedge clk);
        n_rst = 1'b1;
        mark();
        repeat (24) @(negedge clk);
        expect_pkt("after_reset", none, 0, 0, 0);
        tx.push_back(SE0); tx.push_back(SE0); tx.push_back(J);
        mark();
        send(1'b0);
        expect_pkt("reset_next", pl, 1, 1, 0);

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 16);
            jit = 1'($urandom_range(0, 1));
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back($urandom_range(0, 3) != 0);
            build(pl, 1'b1);
            tx.push_back(SE0); tx.push_back(SE0); tx.push_back(J);
            mark();
            send(jit);
            expect_pkt($sformatf("rand%0d", r), pl, 1, 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
Full-speed USB receive front end. It sits directly upstream of the packet CRC checkers.
- Recovers bit timing from asynchronous D+/D- line samples.
- Performs NRZI decoding and bit unstuffing.
- Detects SYNC and EOP.
- Drives bit_out/shift straight into the CRC data/shift inputs and packet_start into their clear input.

Parameters:
CLKS_PER_BIT, 4, clk cycles per USB bit time; even, >=4
SAMPLE_POINT, CLKS_PER_BIT/2, bit-phase count at which the line is sampled

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
dp_in  input  1  raw D+ (asynchronous)
dm_in  input  1  raw D- (asynchronous)
bit_out  output  1  decoded, unstuffed data bit; valid when shift=1, held otherwise
shift  output  1  one-cycle strobe per delivered data bit
packet_start  output  1  one-cycle pulse when SYNC is accepted (CRC clear)
eop  output  1  one-cycle pulse on valid end-of-packet
rx_err  output  1  one-cycle pulse on stuff error, SE0 in SYNC, or malformed EOP
receiving  output  1  high in SYNC, DATA, EOP states

Behaviour:
- Reset is asynchronous on n_rst, active low; clock is clk.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Synchronizers and prev-sample registers load J (dp=1, dm=0).
  - Phase counter 0; ones_count 0.
- Synchronization: two-flop synchronizer on each of dp_in and dm_in. All logic uses the synchronized values.
- Line states (synchronized): J = dp1 dm0; K = dp0 dm1; SE0 = dp0 dm0; dp1 dm1 is treated as J.
- Bit timing:
  - edge = synchronized dp differs from its previous-cycle value.
  - On edge: counter <= 1 (edge cycle is phase 0).
  - Otherwise counter increments, wrapping CLKS_PER_BIT-1 -> 0.
  - sample strobe = (counter == SAMPLE_POINT) && !edge.
- NRZI decode: at each strobe, decoded bit = 1 if sampled dp equals the previous sampled dp, else 0. The previous sampled dp is forced to 1 while in IDLE.
- Output timing: shift/packet_start/eop/rx_err are registered and assert the cycle after the strobe. bit_out updates in the same cycle as shift.
- IDLE:
  - receiving = 0.
  - First sampled K -> SYNC with zero_count = 1 (K after J decodes as 0).
- SYNC (expects decoded 0000000 then 1):
  - Decoded 0: zero_count++. If zero_count would exceed 7 -> IDLE, no error.
  - Decoded 1 with zero_count == 7 -> pulse packet_start, go to DATA, ones_count = 1.
  - Decoded 1 earlier -> IDLE, no pulse.
  - SE0 sampled -> rx_err, go to ERROR.
- DATA, at each strobe:
  - SE0 -> EOP with se0_count = 1; no shift.
  - Else if ones_count == 6: this bit is a stuff bit.
    - Decoded 0 -> discarded, ones_count = 0, no shift.
    - Decoded 1 -> rx_err, go to ERROR.
  - Else emit bit_out = decoded bit with a shift pulse. ones_count = bit ? ones_count+1 : 0.
- EOP:
  - SE0 -> se0_count++; a 4th consecutive SE0 -> rx_err, go to ERROR.
  - J -> pulse eop, go to IDLE.
  - K -> rx_err, go to ERROR.
- ERROR:
  - receiving = 0.
  - Return to IDLE after 2 consecutive J samples; any other sample restarts that count.
- Priority on simultaneous events: edge resync overrides the strobe in that cycle. At most one of shift/packet_start/eop/rx_err is asserted in any cycle.
- Clock tolerance: resync on every transition. Must decode correctly with bit periods of CLKS_PER_BIT±1 clocks between transitions.
- Reset mid-packet: immediate return to the reset state. No eop or rx_err pulse is generated for the abandoned packet.

Test Plan:
- Reset, hold J for 40 clk -> all outputs 0, receiving 0, no strobes escape.
- SYNC KJKJKJKK, data byte 0xA5 LSB-first NRZI, SE0 SE0 J (4 clk/bit):
  - packet_start pulses once, 1 clk after the 8th strobe.
  - 8 shift pulses with bit_out 1,0,1,0,0,1,0,1.
  - eop pulses once after the J sample; receiving falls with it.
- After SYNC, data 1,1,1,1,1, stuffed 0, then 1,0, EOP:
  - 7 shift pulses with bits 1,1,1,1,1,1,0; the stuffed 0 is never shifted.
  - No rx_err.
- After SYNC, six data 1s then a seventh 1:
  - 5 shift pulses, then rx_err pulse; the 6th and 7th bits are not shifted.
  - receiving goes 0; after J,J a following valid packet produces packet_start.
- Bad SYNC K J K J K K K K K (9 bits) -> no packet_start, returns to IDLE, no rx_err. SE0 inserted mid-SYNC -> rx_err pulse.
- 0xA5 packet with bit periods alternating 3 and 5 clk -> identical bits to the nominal case. Assert n_rst mid-byte -> outputs 0 immediately, no eop; the next packet decodes normally.
